// File: rtl/pipelined_adder_pkg.sv
// Shared types and constants for the carry-pipelined adder/subtractor.
// The overflow output is enabled by defining PIPELINED_ADDER_OVF_DETECT_EN.
package pipelined_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipelined_adder_chunk_adder.sv
// Purely combinational W-bit ripple adder; also exposes the carry into the
// MSB so the last slice can produce signed overflow.
module chunk_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    always_comb begin
        logic carry;
        sum   = '0;
        c_msb = 1'b0;
        // NOTE: blocking assignments here; the carry must ripple bit to bit within one evaluation.
        carry = cin;
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) begin
                c_msb = carry;
            end
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice per stage,
// valid/ready on both sides. Optional out_ovf via PIPELINED_ADDER_OVF_DETECT_EN.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef PIPELINED_ADDER_OVF_DETECT_EN
    , output logic           out_ovf
`endif
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    op_e              op;
    logic [WIDTH-1:0] eff_b;
    logic             eff_cin;
    logic             advance;

    // Per-stage operand inputs to the slice adders.
    logic [WIDTH-1:0] stg_a   [STAGES];
    logic [WIDTH-1:0] stg_b   [STAGES];
    logic [STAGES-1:0] stg_cin;

    logic [CHUNK-1:0]  slice_sum [STAGES];
    logic [STAGES-1:0] slice_cout;
    logic [STAGES-1:0] slice_cmsb;

    // a_q[k]: finished sum slices shifted in at the top, unprocessed A bits
    // at the bottom; after the last stage it holds the full aligned sum.
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [STAGES-1:0] valid_d, valid_q;
    logic [STAGES-1:0] carry_d, carry_q;
`ifdef PIPELINED_ADDER_OVF_DETECT_EN
    logic              ovf_d, ovf_q;
`endif

    always_comb begin
        op      = op_e'(in_sub);
        eff_b   = (op == OP_SUB) ? ~in_b : in_b;
        eff_cin = (op == OP_SUB) ? 1'b1 : in_cin;

        stg_a[0]   = in_a;
        stg_b[0]   = eff_b;
        stg_cin[0] = eff_cin;
        for (int k = 1; k < STAGES; k++) begin
            stg_a[k]   = a_q[k-1];
            stg_b[k]   = b_q[k-1];
            stg_cin[k] = carry_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        chunk_adder #(.W(CHUNK)) u_chunk_adder (
            .a     (stg_a[k][CHUNK-1:0]),
            .b     (stg_b[k][CHUNK-1:0]),
            .cin   (stg_cin[k]),
            .sum   (slice_sum[k]),
            .cout  (slice_cout[k]),
            .c_msb (slice_cmsb[k])
        );
    end

    always_comb begin
        valid_d    = '0;
        valid_d[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
        end
        carry_d = slice_cout;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k] = (stg_a[k] >> CHUNK) | (WIDTH'(slice_sum[k]) << (WIDTH - CHUNK));
            b_d[k] = stg_b[k] >> CHUNK;
        end
`ifdef PIPELINED_ADDER_OVF_DETECT_EN
        ovf_d = slice_cmsb[STAGES-1] ^ slice_cout[STAGES-1];
`endif
    end

    // The whole pipe moves or holds as one; bubbles are never collapsed.
    assign advance = !valid_q[STAGES-1] || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: data registers are reset too, so out_sum reads 0 after reset rather than X.
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
`ifdef PIPELINED_ADDER_OVF_DETECT_EN
            ovf_q <= 1'b0;
`endif
        end else if (advance) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
            end
`ifdef PIPELINED_ADDER_OVF_DETECT_EN
            ovf_q <= ovf_d;
`endif
        end
    end

    assign in_ready  = advance;
    assign out_valid = valid_q[STAGES-1];
    assign out_sum   = a_q[STAGES-1];
    assign out_cout  = carry_q[STAGES-1];
`ifdef PIPELINED_ADDER_OVF_DETECT_EN
    assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: an 8-bit/2-stage and a 32-bit/4-stage
// instance; out_ovf checks are included when PIPELINED_ADDER_OVF_DETECT_EN is defined.
module tb_pipelined_adder;

    logic clk;
    logic rst;

    logic       iv8, ir8, ov8, ord8, cin8, sub8, cout8;
    logic [7:0] a8, b8, sum8;
    logic        iv32, ir32, ov32, ord32, cin32, sub32, cout32;
    logic [31:0] a32, b32, sum32;
`ifdef PIPELINED_ADDER_OVF_DETECT_EN
    logic ovf8, ovf32;
`endif

    int vectors    = 0;
    int miscompares = 0;

    pipelined_adder #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .in_a      (a8),
        .in_b      (b8),
        .in_cin    (cin8),
        .in_sub    (sub8),
        .out_valid (ov8),
        .out_ready (ord8),
        .out_sum   (sum8),
        .out_cout  (cout8)
`ifdef PIPELINED_ADDER_OVF_DETECT_EN
        , .out_ovf (ovf8)
`endif
    );

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv32),
        .in_ready  (ir32),
        .in_a      (a32),
        .in_b      (b32),
        .in_cin    (cin32),
        .in_sub    (sub32),
        .out_valid (ov32),
        .out_ready (ord32),
        .out_sum   (sum32),
        .out_cout  (cout32)
`ifdef PIPELINED_ADDER_OVF_DETECT_EN
        , .out_ovf (ovf32)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] bb_a   [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    logic [7:0] bb_b   [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] bb_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; ord8 = 1'b1;
        iv32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; ord32 = 1'b1;

        // Reset state
        repeat (2) step();
        check("rst_valid8", ov8, 0);
        check("rst_sum8", sum8, 0);
        check("rst_cout8", cout8, 0);
        check("rst_valid32", ov32, 0);
        check("rst_sum32", sum32, 0);
`ifdef PIPELINED_ADDER_OVF_DETECT_EN
        check("rst_ovf8", ovf8, 0);
`endif
        rst = 1'b0;
        #1;
        check("rst_in_ready8", ir8, 1);
        step();

        // Add with wrap: 0xFF + 0x01 -> 0x00, cout=1, valid for exactly one cycle
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
        step();
        iv8 = 1'b0;
        #1;
        check("wrap_early_valid", ov8, 0);
        step();
        check("wrap_valid", ov8, 1);
        check("wrap_sum", sum8, 8'h00);
        check("wrap_cout", cout8, 1);
        step();
        check("wrap_valid_drop", ov8, 0);

        // Subtract: 5-7 borrows, 7-5 does not; cin must be ignored
        a8 = 8'h05; b8 = 8'h07; cin8 = 1'b1; sub8 = 1'b1; iv8 = 1'b1;
        step();
        a8 = 8'h07; b8 = 8'h05;
        step();
        iv8 = 1'b0;
        check("sub_borrow_valid", ov8, 1);
        check("sub_borrow_sum", sum8, 8'hFE);
        check("sub_borrow_cout", cout8, 0);
        step();
        check("sub_noborrow_sum", sum8, 8'h02);
        check("sub_noborrow_cout", cout8, 1);
        step();
        cin8 = 1'b0; sub8 = 1'b0;

        // Back-to-back: four beats, four results on consecutive cycles
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                a8 = bb_a[i]; b8 = bb_b[i]; iv8 = 1'b1;
            end else begin
                iv8 = 1'b0;
            end
            step();
            if (i >= 1) begin
                check($sformatf("b2b_valid_%0d", i - 1), ov8, 1);
                check($sformatf("b2b_sum_%0d", i - 1), sum8, bb_exp[i-1]);
            end
        end
        step();
        check("b2b_drained", ov8, 0);

        // Backpressure with two beats in flight, a third waiting at the input
        a8 = 8'h0A; b8 = 8'h05; iv8 = 1'b1;
        step();
        a8 = 8'h30; b8 = 8'h0C; ord8 = 1'b0;
        step();
        a8 = 8'h50; b8 = 8'h50;
        check("bp_in_ready0", ir8, 0);
        check("bp_valid0", ov8, 1);
        check("bp_sum0", sum8, 8'h0F);
        step();
        check("bp_in_ready1", ir8, 0);
        check("bp_sum1", sum8, 8'h0F);
        step();
        check("bp_valid2", ov8, 1);
        check("bp_sum2", sum8, 8'h0F);
        ord8 = 1'b1;
        #1;
        check("bp_release_ready", ir8, 1);
        step();
        iv8 = 1'b0;
        check("bp_drain1_valid", ov8, 1);
        check("bp_drain1_sum", sum8, 8'h3C);
        step();
        check("bp_drain2_valid", ov8, 1);
        check("bp_drain2_sum", sum8, 8'hA0);
        check("bp_drain2_cout", cout8, 0);
        step();
        check("bp_no_dup", ov8, 0);

`ifdef PIPELINED_ADDER_OVF_DETECT_EN
        // Signed overflow
        a8 = 8'h7F; b8 = 8'h01; sub8 = 1'b0; iv8 = 1'b1;
        step();
        a8 = 8'h80; b8 = 8'h01; sub8 = 1'b1;
        step();
        a8 = 8'h01; b8 = 8'h01; sub8 = 1'b0;
        check("ovf_add_sum", sum8, 8'h80);
        check("ovf_add_ovf", ovf8, 1);
        step();
        iv8 = 1'b0;
        check("ovf_sub_sum", sum8, 8'h7F);
        check("ovf_sub_ovf", ovf8, 1);
        step();
        check("ovf_none_sum", sum8, 8'h02);
        check("ovf_none_ovf", ovf8, 0);
        step();
`endif

        // Reset mid-flight: one beat at the output, one still inside
        a8 = 8'h11; b8 = 8'h22; iv8 = 1'b1;
        step();
        a8 = 8'h44; b8 = 8'h11;
        step();
        iv8 = 1'b0;
        check("midrst_pre_valid", ov8, 1);
        check("midrst_pre_sum", sum8, 8'h33);
        rst = 1'b1;
        #1;
        check("midrst_async_valid", ov8, 0);
        check("midrst_async_sum", sum8, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("midrst_lost_%0d", i), ov8, 0);
        end

        // 32-bit, 4 stages: carries crossing slice boundaries, latency 4
        a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; sub32 = 1'b0; iv32 = 1'b1;
        step();
        a32 = 32'h0000_FFFF; b32 = 32'h0000_0001;
        step();
        a32 = 32'h8000_0000; b32 = 32'h0000_0001; sub32 = 1'b1;
        step();
        iv32 = 1'b0; sub32 = 1'b0;
        check("w32_lat3_valid", ov32, 0);
        step();
        check("w32_b0_valid", ov32, 1);
        check("w32_b0_sum", sum32, 32'h0000_0000);
        check("w32_b0_cout", cout32, 1);
`ifdef PIPELINED_ADDER_OVF_DETECT_EN
        check("w32_b0_ovf", ovf32, 0);
`endif
        step();
        check("w32_b1_sum", sum32, 32'h0001_0000);
        check("w32_b1_cout", cout32, 0);
        step();
        check("w32_b2_sum", sum32, 32'h7FFF_FFFF);
        check("w32_b2_cout", cout32, 1);
`ifdef PIPELINED_ADDER_OVF_DETECT_EN
        check("w32_b2_ovf", ovf32, 1);
`endif
        step();
        check("w32_drained", ov32, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
